// File: rtl/cfg_apb_bridge_if.sv
// APB3 bus bundle between the CPU-side master and the configuration bridge.
interface cfg_apb_bridge_if #(
    parameter int ADDR_W = 64
);
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [31:0]       pwdata;
    logic [31:0]       prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/cfg_apb_bridge.sv
// APB3 slave that turns CPU configuration accesses into the internal register
// bus feeding the configuration mux: registered address/write data, a
// one-cycle write strobe, and a fixed-latency sample of the mux read data.
module cfg_apb_bridge #(
    parameter int ADDR_W  = 64,
    parameter int NUM_SUB = 4,
    parameter int RD_LAT  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    cfg_apb_bridge_if.slave   apb,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [31:0]       reg_wr_data,
    output logic              reg_wr_en,
    input  logic [31:0]       reg_rd_data
);
    // RD_LAT >= 2, so this width always holds RD_LAT-1.
    localparam int CNT_W = $clog2(RD_LAT);

    typedef enum logic [1:0] {IDLE, WR, RD, RESP} state_t;

    state_t            state_reg,   state_next;
    logic [CNT_W-1:0]  cnt_reg,     cnt_next;
    logic              err_reg,     err_next;
    logic [ADDR_W-1:0] addr_reg,    addr_next;
    logic [31:0]       wdata_reg,   wdata_next;
    logic              wr_en_reg,   wr_en_next;
    logic [31:0]       prdata_reg,  prdata_next;
    logic              pready_reg,  pready_next;
    logic              pslverr_reg, pslverr_next;

    logic setup;
    logic err_calc;

    assign setup    = apb.psel & ~apb.penable;
    // Sub-block index above the decoded range, or a non-word-aligned address.
    assign err_calc = (apb.paddr[ADDR_W-1:13] >= (ADDR_W-13)'(NUM_SUB)) |
                      (apb.paddr[1:0] != 2'b00);

    // Next-state and output-register logic; every register holds by default.
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        err_next     = err_reg;
        addr_next    = addr_reg;
        wdata_next   = wdata_reg;
        wr_en_next   = 1'b0;
        prdata_next  = prdata_reg;
        pready_next  = pready_reg;
        pslverr_next = pslverr_reg;

        case (state_reg)
            IDLE: begin
                if (setup) begin
                    addr_next  = apb.paddr;
                    wdata_next = apb.pwdata;
                    err_next   = err_calc;
                    if (apb.pwrite) begin
                        state_next = WR;
                        // Strobe is registered so it is high exactly while in WR.
                        wr_en_next = ~err_calc;
                    end else begin
                        state_next = RD;
                        cnt_next   = CNT_W'(RD_LAT - 1);
                    end
                end
            end
            WR: begin
                state_next   = RESP;
                prdata_next  = 32'd0;
                pready_next  = 1'b1;
                pslverr_next = err_reg;
            end
            RD: begin
                if (cnt_reg == '0) begin
                    state_next   = RESP;
                    prdata_next  = err_reg ? 32'd0 : reg_rd_data;
                    pready_next  = 1'b1;
                    pslverr_next = err_reg;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            RESP: begin
                // Normal completion or master abort both return to IDLE.
                if (apb.penable | ~apb.psel) begin
                    state_next   = IDLE;
                    pready_next  = 1'b0;
                    pslverr_next = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            err_reg     <= 1'b0;
            addr_reg    <= '0;
            wdata_reg   <= '0;
            wr_en_reg   <= 1'b0;
            prdata_reg  <= '0;
            pready_reg  <= 1'b0;
            pslverr_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            err_reg     <= err_next;
            addr_reg    <= addr_next;
            wdata_reg   <= wdata_next;
            wr_en_reg   <= wr_en_next;
            prdata_reg  <= prdata_next;
            pready_reg  <= pready_next;
            pslverr_reg <= pslverr_next;
        end
    end

    assign reg_addr    = addr_reg;
    assign reg_wr_data = wdata_reg;
    assign reg_wr_en   = wr_en_reg;
    assign apb.prdata  = prdata_reg;
    assign apb.pready  = pready_reg;
    assign apb.pslverr = pslverr_reg;
endmodule
